// File: rtl/ulpi_pkg.sv
// rtl/ulpi_pkg.sv - shared constants, state encoding and request record for the ULPI link sequencer
package ulpi_pkg;

    localparam logic [1:0] TXCMD_REGW = 2'b10;
    localparam logic [1:0] TXCMD_REGR = 2'b11;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_TXCMD   = 4'd1;
    localparam logic [3:0] ST_WDATA   = 4'd2;
    localparam logic [3:0] ST_STP     = 4'd3;
    localparam logic [3:0] ST_RD_TA1  = 4'd4;
    localparam logic [3:0] ST_RD_DATA = 4'd5;
    localparam logic [3:0] ST_RD_TA2  = 4'd6;
    localparam logic [3:0] ST_ABORT   = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;

    // USB3300 immediate register map
    localparam logic [5:0] REG_VID_LOW   = 6'h00;
    localparam logic [5:0] REG_FUNC_CTRL = 6'h04;
    localparam logic [5:0] REG_IFC_CTRL  = 6'h07;
    localparam logic [5:0] REG_OTG_CTRL  = 6'h0A;
    localparam logic [5:0] REG_DEBUG     = 6'h15;
    localparam logic [5:0] REG_SCRATCH   = 6'h16;

    typedef struct packed {
        logic       sel;
        logic       we;
        logic [5:0] addr;
        logic [7:0] wdata;
    } ulpi_req_t;

    function automatic logic [7:0] txcmd_byte(input logic we, input logic [5:0] addr);
        return {(we ? TXCMD_REGW : TXCMD_REGR), addr};
    endfunction

endpackage

// File: rtl/ulpi_link_ctrl_if.sv
// rtl/ulpi_link_ctrl_if.sv - ULPI pad bundle and register-requester port bundle
interface ulpi_bus_if;
    logic       dir;
    logic       nxt;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe;
    logic       stp;

    modport master (input dir, nxt, din, output dout, oe, stp);
    modport slave  (output dir, nxt, din, input dout, oe, stp);
endinterface

interface ulpi_reg_if;
    logic       req;
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       done;
    logic       err;
    logic [7:0] rdata;

    modport master (output req, we, addr, wdata, input done, err, rdata);
    modport slave  (input req, we, addr, wdata, output done, err, rdata);
endinterface

// File: rtl/ulpi_rr_arb.sv
// rtl/ulpi_rr_arb.sv - two-port round-robin grant; pointer moves past the port that just completed
module ulpi_rr_arb (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic en,
    input  logic done,
    input  logic done_sel,
    output logic gnt,
    output logic gnt_sel
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt     = en && (req_a || req_b);
        gnt_sel = (req_a && req_b) ? ptr_q : req_b;
        ptr_d   = done ? ~done_sel : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ulpi_link_ctrl.sv
// rtl/ulpi_link_ctrl.sv - single-owner ULPI sequencer: arbitrated register access plus RX CMD/data capture
module ulpi_link_ctrl
    import ulpi_pkg::*;
#(
    parameter int unsigned NXT_TIMEOUT = 255,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    ulpi_bus_if.master  ulpi,
    ulpi_reg_if.slave   port_a,
    ulpi_reg_if.slave   port_b,
    output logic [7:0]  rx_cmd,
    output logic        rx_cmd_vld,
    output logic [7:0]  rx_data,
    output logic        rx_data_vld,
    output logic        busy
);

    localparam logic [7:0] TMO_LAST  = 8'(NXT_TIMEOUT - 1);
    localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

    logic [3:0] state_q, state_d;
    logic       dir_q, dir_d;
    ulpi_req_t  req_q, req_d;
    logic [7:0] tmo_q, tmo_d;
    logic [1:0] retry_q, retry_d;
    logic       err_q, err_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] rx_cmd_q, rx_cmd_d, rx_data_q, rx_data_d;
    logic       rx_cmd_vld_q, rx_cmd_vld_d, rx_data_vld_q, rx_data_vld_d;

    logic       bus_idle, rx_phase, gnt, gnt_sel, done_st;
    logic [7:0] dout_c;

    assign bus_idle = !ulpi.dir && !dir_q;
    // In RD_DATA the PHY is returning the register value, not an RX stream byte
    assign rx_phase = ulpi.dir && dir_q && (state_q != ST_RD_DATA);
    assign done_st  = (state_q == ST_DONE);

    ulpi_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_a    (port_a.req),
        .req_b    (port_b.req),
        .en       ((state_q == ST_IDLE) && bus_idle),
        .done     (done_st),
        .done_sel (req_q.sel),
        .gnt      (gnt),
        .gnt_sel  (gnt_sel)
    );

    always_comb begin
        state_d       = state_q;
        dir_d         = ulpi.dir;
        req_d         = req_q;
        tmo_d         = tmo_q;
        retry_d       = retry_q;
        err_d         = err_q;
        rdata_d       = rdata_q;
        rx_cmd_d      = rx_cmd_q;
        rx_cmd_vld_d  = 1'b0;
        rx_data_d     = rx_data_q;
        rx_data_vld_d = 1'b0;

        if (rx_phase) begin
            if (ulpi.nxt) begin
                rx_data_d     = ulpi.din;
                rx_data_vld_d = 1'b1;
            end else begin
                rx_cmd_d     = ulpi.din;
                rx_cmd_vld_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (gnt) begin
                    req_d.sel   = gnt_sel;
                    req_d.we    = gnt_sel ? port_b.we    : port_a.we;
                    req_d.addr  = gnt_sel ? port_b.addr  : port_a.addr;
                    req_d.wdata = gnt_sel ? port_b.wdata : port_a.wdata;
                    err_d       = 1'b0;
                    rdata_d     = 8'h00;
                    tmo_d       = 8'h00;
                    state_d     = ST_TXCMD;
                end
            end
            ST_TXCMD: begin
                tmo_d = tmo_q + 8'd1;
                // A read accepted in the same cycle dir rises is the normal turnaround
                if (ulpi.nxt && !(req_q.we && ulpi.dir))
                    state_d = req_q.we ? ST_WDATA : ST_RD_TA1;
                else if (ulpi.dir || (tmo_q == TMO_LAST))
                    state_d = ST_ABORT;
            end
            ST_WDATA: begin
                if (ulpi.dir)      state_d = ST_ABORT;
                else if (ulpi.nxt) state_d = ST_STP;
            end
            ST_STP: state_d = ST_DONE;
            ST_RD_TA1: begin
                if (dir_q && ulpi.nxt) state_d = ST_ABORT;
                else                   state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                rdata_d = ulpi.din;
                state_d = ST_RD_TA2;
            end
            ST_RD_TA2: begin
                if (!ulpi.dir) state_d = ST_DONE;
            end
            ST_ABORT: begin
                if (retry_q == RETRY_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (bus_idle) begin
                    retry_d = retry_q + 2'd1;
                    tmo_d   = 8'h00;
                    state_d = ST_TXCMD;
                end
            end
            ST_DONE: begin
                retry_d = 2'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            dir_q         <= 1'b0;
            req_q         <= '0;
            tmo_q         <= 8'h00;
            retry_q       <= 2'd0;
            err_q         <= 1'b0;
            rdata_q       <= 8'h00;
            rx_cmd_q      <= 8'h00;
            rx_cmd_vld_q  <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_data_vld_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            req_q         <= req_d;
            tmo_q         <= tmo_d;
            retry_q       <= retry_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            rx_cmd_q      <= rx_cmd_d;
            rx_cmd_vld_q  <= rx_cmd_vld_d;
            rx_data_q     <= rx_data_d;
            rx_data_vld_q <= rx_data_vld_d;
        end
    end

    always_comb begin
        dout_c = 8'h00;
        case (state_q)
            ST_TXCMD: dout_c = txcmd_byte(req_q.we, req_q.addr);
            ST_WDATA: dout_c = req_q.wdata;
            default:  dout_c = 8'h00;
        endcase
    end

    assign ulpi.dout = dout_c;
    assign ulpi.oe   = ((state_q == ST_TXCMD) || (state_q == ST_WDATA) || (state_q == ST_STP)) && bus_idle;
    assign ulpi.stp  = (state_q == ST_STP);

    assign port_a.done  = done_st && !req_q.sel;
    assign port_a.err   = done_st && !req_q.sel && err_q;
    assign port_a.rdata = (done_st && !req_q.sel) ? rdata_q : 8'h00;
    assign port_b.done  = done_st && req_q.sel;
    assign port_b.err   = done_st && req_q.sel && err_q;
    assign port_b.rdata = (done_st && req_q.sel) ? rdata_q : 8'h00;

    assign rx_cmd      = rx_cmd_q;
    assign rx_cmd_vld  = rx_cmd_vld_q;
    assign rx_data     = rx_data_q;
    assign rx_data_vld = rx_data_vld_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/ulpi_link_ctrl.md
Name: ulpi_link_ctrl

Overview:
- Single-owner sequencer for the USB3300 ULPI bus; clocked from the PHY's 60 MHz clock.
- Arbitrates two register-access requesters: port A (init/config) and port B (runtime/UART command).
- Executes immediate register write and read transactions on ULPI. Captures RX CMD and packet bytes whenever the PHY owns the bus (DIR=1).
- Replaces per-requester direct pin driving. The sniffer datapath consumes its rx_* outputs.

Parameters:
- NXT_TIMEOUT, 255: cycles to wait for NXT after TXCMD before abort; 8-bit counter.
- MAX_RETRY, 3: retries after a DIR-abort or timeout before reporting an error; 2-bit counter.

Ports:
- clk  in  1  ULPI 60 MHz clock
- rst  in  1  asynchronous, active-high reset
- ulpi_dir  in  1  PHY bus ownership
- ulpi_nxt  in  1  PHY throttle/next
- ulpi_din  in  8  data from pads
- ulpi_dout  out  8  data to pads
- ulpi_oe  out  1  pad output enable
- ulpi_stp  out  1  stop
- a_req  in  1  port A request (level; hold until a_done)
- a_we  in  1  1=write, 0=read
- a_addr  in  6  register address
- a_wdata  in  8  write data
- a_done  out  1  1-cycle completion pulse
- a_err  out  1  valid with a_done; retries exhausted
- a_rdata  out  8  read data, valid with a_done
- b_req, b_we, b_addr, b_wdata, b_done, b_err, b_rdata: same as port A
- rx_cmd  out  8  last RX CMD byte
- rx_cmd_vld  out  1  1-cycle pulse on RX CMD capture
- rx_data  out  8  packet byte
- rx_data_vld  out  1  1-cycle pulse per packet byte
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0; FSM=IDLE; RR pointer=A; counters 0. The reset is async assert; deassertion is synchronised by the top level.
- Turnaround tracking: dir_q registers ulpi_dir. Cycles where ulpi_dir!=dir_q are turnaround: no capture, ulpi_oe=0.
- ulpi_oe: 1 only in TXCMD/WDATA/STP states with ulpi_dir=0; otherwise 0 combinationally on ulpi_dir=1.
- RX capture (any state): ulpi_dir=1 and dir_q=1.
  - nxt=0: rx_cmd<=din, rx_cmd_vld pulse.
  - nxt=1: rx_data<=din, rx_data_vld pulse. This does not apply in RD_DATA, where the byte is the register value.
- Arbitration in IDLE, only when ulpi_dir=0 and dir_q=0:
  - Grant a single requester.
  - If both request, grant the RR pointer side; the pointer flips to the other port after each completed (done) transaction.
- FSM states:
  - IDLE: on grant, latch we/addr/wdata; go to TXCMD.
  - TXCMD: dout = {we?2'b10:2'b11, addr}.
    - nxt=1 → WDATA (write) or RD_TA1 (read).
    - ulpi_dir=1 → ABORT.
    - Timeout counter reaching NXT_TIMEOUT → ABORT.
  - WDATA: dout=wdata.
    - nxt=1 → STP.
    - ulpi_dir=1 → ABORT.
  - STP: ulpi_stp=1 and dout=0 for exactly 1 cycle → DONE.
  - RD_TA1: expects ulpi_dir=1 (turnaround).
    - dir already high last cycle with nxt=1 → ABORT (PHY RX preempted).
    - Otherwise → RD_DATA.
  - RD_DATA: rdata<=din → RD_TA2.
  - RD_TA2: wait ulpi_dir=0 → DONE.
  - ABORT: increment retry.
    - retry==MAX_RETRY → DONE with err=1.
    - Otherwise wait ulpi_dir=0 and dir_q=0 → TXCMD with the same latched request. No re-arbitration.
  - DONE: pulse x_done (+x_err, x_rdata) to the granted port; clear retry → IDLE.
- Latency, no contention:
  - Write: TXCMD→done = 4 cycles, with nxt asserted the first cycle of TXCMD and WDATA.
  - Read: 5 cycles.
- Simultaneous events: ulpi_dir rising in the same cycle nxt=1 during TXCMD counts as accepted for reads (normal turnaround) and as abort for writes.
- Requester dropping req mid-transaction: ignored; the transaction completes and done still pulses.
- Reset mid-transaction: immediate return to IDLE; oe=0 and stp=0 asynchronously.

Decomposition:
- Shared package ulpi_pkg:
  - TXCMD prefixes: REGW=2'b10, REGR=2'b11.
  - FSM state encoding.
  - USB3300 register address constants (FUNC_CTRL=6'h04, OTG_CTRL=6'h0A, ...).
- One natural sub-module: ulpi_rr_arb (2-port round-robin grant with pointer update on done).

Test Plan:
- Port A write addr 0x04 data 0x48, PHY asserts nxt the cycle after TXCMD appears → dout 0x84, then 0x48; stp=1 for 1 cycle; a_done on cycle 4; a_err=0.
- Port B read addr 0x0A, PHY nxt then dir=1, din=0x06 → dout 0xCA; b_rdata=0x06 with b_done; oe=0 during dir=1.
- PHY asserts dir with nxt=0, din=0x4D during A write TXCMD → rx_cmd=0x4D with rx_cmd_vld. Write retried after dir falls; completes with a_err=0.
- A and B request together twice → grants A, B, A, B in order; no overlap of done pulses.
- nxt never asserted → abort after 255 cycles; retried 3 times; a_done with a_err=1.
- rst asserted during WDATA → next edge-independent: oe=0, stp=0, busy=0; a new request after rst deasserts completes normally.
